bcd_subtractor_serial: RTL and testbench

- Digit-serial multi-digit BCD subtractor; the inverse operation of the team's BCD adder.
- Computes |A - B| for packed-BCD operands, one digit per clock, LSD first, with a sign flag.
- A second serial ten's-complement pass produces the magnitude when the result is negative.
- Sits beside the BCD adder in the decimal arithmetic path; uses a start/busy/done handshake.

---
 rtl/bcd_subtractor_serial.sv | 161 ++++++++++++++++
 tb/tb_bcd_subtractor_serial.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bcd_subtractor_serial.sv
// rtl/bcd_subtractor_serial.sv - digit-serial packed-BCD subtractor producing |A-B| with sign flag
//
// Computes |A - B| one BCD digit per clock, least significant digit first.
// When the straight subtraction ends with a borrow the result is 10^DIGITS - |A-B|,
// so a second serial pass (0 - r - borrow) turns it into the magnitude.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   start  - operation request, accepted only while idle
//   A, B   - minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   busy   - high from acceptance through the done cycle
//   done   - one-cycle pulse when D/neg/err are valid
//   D      - |A-B| in packed BCD, held until the next accepted start
//   neg    - A < B
//   err    - some input nibble was not a BCD digit
module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   D,
    output logic                  neg,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_COMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [4*DIGITS-1:0]  a_q, b_q, r_q;
    logic [IW-1:0]        idx_q;
    logic                 borrow_q;
    logic                 neg_q, err_q;

    logic [3:0]           a_dig, b_dig, r_dig;
    logic [3:0]           x_dig, y_dig, r_new;
    logic [4:0]           t;
    logic                 borrow_n;
    logic                 last;
    logic                 bad_in;

    function automatic logic has_bad(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign bad_in = has_bad(A) | has_bad(B);
    assign last   = (idx_q == LAST);

    // Select the current digit of each operand and of the partial result.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        r_dig = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IW'(d)) begin
                a_dig = a_q[4*d +: 4];
                b_dig = b_q[4*d +: 4];
                r_dig = r_q[4*d +: 4];
            end
        end
    end

    // One shared digit subtractor: SUB does a-b, COMP does 0-r.
    // A negative 5-bit t lies in -10..-1, so adding 10 to its low nibble
    // (mod 16) yields the correct decimal digit.
    always_comb begin
        x_dig    = (state_q == S_SUB) ? a_dig : 4'd0;
        y_dig    = (state_q == S_SUB) ? b_dig : r_dig;
        t        = {1'b0, x_dig} - {1'b0, y_dig} - {4'd0, borrow_q};
        borrow_n = t[4];
        r_new    = t[4] ? (t[3:0] + 4'd10) : t[3:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = bad_in ? S_DONE : S_SUB;
            S_SUB:  if (last)  state_d = borrow_n ? S_COMP : S_DONE;
            S_COMP: if (last)  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign D   = r_q;
    assign neg = neg_q;
    assign err = err_q;

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        r_q      <= '0;
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        neg_q    <= 1'b0;
                        err_q    <= bad_in;
                    end
                end
                S_SUB, S_COMP: begin
                    for (int d = 0; d < DIGITS; d++) begin
                        if (idx_q == IW'(d)) r_q[4*d +: 4] <= r_new;
                    end
                    if (last) begin
                        idx_q    <= '0;
                        borrow_q <= 1'b0;
                        if (state_q == S_SUB && borrow_n) neg_q <= 1'b1;
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        borrow_q <= borrow_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// tb/tb_bcd_subtractor_serial.sv - directed self-checking bench for bcd_subtractor_serial
module tb_bcd_subtractor_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A, B;
    logic        busy, done, neg, err;
    logic [15:0] D;

    int errors = 0;
    int checks = 0;

    bcd_subtractor_serial #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .neg   (neg),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to done. Inputs change on negedges,
    // outputs are sampled on negedges. Cycle n is the one after the n-th
    // rising edge counting the edge that samples start as the first.
    // poke1/poke2: cycles in which a spurious start with junk operands is driven.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input int exp_lat, input logic [15:0] exp_d,
                          input logic exp_neg, input logic exp_err,
                          input int poke1, input int poke2);
        int cyc;
        int done_cnt;
        int lat;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 16'h9876; B = 16'h0123;
        lat = -1;
        done_cnt = 0;
        for (cyc = 1; cyc <= 30; cyc++) begin
            if (cyc > 1) @(negedge clk);
            start = (cyc == poke1 || cyc == poke2);
            if (start) begin A = 16'h9999; B = 16'h0001; end
            chk({tag, " busy"}, busy, 1'b1);
            if (done) begin
                lat = cyc;
                done_cnt++;
                break;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " D"}, D, exp_d);
        chk({tag, " neg"}, neg, exp_neg);
        chk({tag, " err"}, err, exp_err);
        // Stay idle a few cycles: results hold, no further done.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_cnt++;
            chk({tag, " idle busy"}, busy, 1'b0);
            chk({tag, " hold D"}, D, exp_d);
            chk({tag, " hold neg"}, neg, exp_neg);
            chk({tag, " hold err"}, err, exp_err);
        end
        chk({tag, " done pulses"}, done_cnt, 1);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset D", D, 16'h0);
        chk("reset neg", neg, 1'b0);
        chk("reset err", err, 1'b0);
        rst_n = 1'b1;

        run_op("5432-1234", 16'h5432, 16'h1234, 5, 16'h4198, 1'b0, 1'b0, 0, 0);
        run_op("1234-5432", 16'h1234, 16'h5432, 9, 16'h4198, 1'b1, 1'b0, 0, 0);
        run_op("1000-0001", 16'h1000, 16'h0001, 5, 16'h0999, 1'b0, 1'b0, 0, 0);
        run_op("0000-0000", 16'h0000, 16'h0000, 5, 16'h0000, 1'b0, 1'b0, 0, 0);
        run_op("0000-9999", 16'h0000, 16'h9999, 9, 16'h9999, 1'b1, 1'b0, 0, 0);
        run_op("err 12A4",  16'h12A4, 16'h0001, 1, 16'h0000, 1'b0, 1'b1, 0, 0);
        run_op("err 000F",  16'h0005, 16'h000F, 1, 16'h0000, 1'b0, 1'b1, 0, 0);
        run_op("ignored start", 16'h5432, 16'h1234, 5, 16'h4198, 1'b0, 1'b0, 2, 5);
        run_op("9999-0000", 16'h9999, 16'h0000, 5, 16'h9999, 1'b0, 1'b0, 0, 0);

        // Reset in the middle of the complement pass.
        @(negedge clk);
        A = 16'h1234; B = 16'h5432; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("pre-abort busy", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", busy, 1'b0);
        chk("abort D", D, 16'h0);
        chk("abort neg", neg, 1'b0);
        chk("abort done", done, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort no done", dn, 0);
        run_op("after abort", 16'h1234, 16'h5432, 9, 16'h4198, 1'b1, 1'b0, 0, 0);
        run_op("0100-0099", 16'h0100, 16'h0099, 5, 16'h0001, 1'b0, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
